// File: rtl/message_display_arbiter.sv
// Selects what drives the seven-segment display: the game, or a SUCCESS/FAIL message.
// A message is shown after a short blank gap and then holds the display for a fixed time.
module message_display_arbiter #(
    parameter logic [31:0] HOLD_CYCLES  = 32'd400_000_000,
    parameter logic [31:0] BLANK_CYCLES = 32'd10_000_000
) (
    input  logic       basys_clock,
    input  logic       reset,
    input  logic [7:0] game_seg,
    input  logic [3:0] game_an,
    input  logic [7:0] success_seg,
    input  logic [3:0] success_an,
    input  logic [7:0] fail_seg,
    input  logic [3:0] fail_an,
    input  logic       success_trig,
    input  logic       fail_trig,
    output logic [7:0] seg,
    output logic [3:0] an,
    output logic       msg_active,
    output logic       msg_kind,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        GAME  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    // A zero-length phase still occupies one cycle, so its last count is 0.
    localparam logic [31:0] BLANK_LAST = (BLANK_CYCLES == 32'd0) ? 32'd0 : BLANK_CYCLES - 32'd1;
    localparam logic [31:0] HOLD_LAST  = (HOLD_CYCLES  == 32'd0) ? 32'd0 : HOLD_CYCLES  - 32'd1;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        s_trig_q, s_trig_d;
    logic        f_trig_q, f_trig_d;
    logic        msg_kind_q, msg_kind_d;
    logic        msg_active_q, msg_active_d;
    logic [7:0]  seg_q, seg_d;
    logic [3:0]  an_q, an_d;
    logic        s_rise, f_rise;

    always_comb begin
        s_rise     = success_trig & ~s_trig_q;
        f_rise     = fail_trig & ~f_trig_q;
        s_trig_d   = success_trig;
        f_trig_d   = fail_trig;
        state_d    = state_q;
        cnt_d      = cnt_q;
        msg_kind_d = msg_kind_q;

        if (state_q == GAME) begin
            cnt_d = 32'd0;
            if (f_rise || s_rise) begin
                state_d    = BLANK;
                msg_kind_d = f_rise;
            end
        end else if (state_q == BLANK || state_q == SHOW) begin
            // Fail preempts success; a same-kind rise restarts the current phase.
            if (f_rise && !msg_kind_q) begin
                state_d    = BLANK;
                msg_kind_d = 1'b1;
                cnt_d      = 32'd0;
            end else if (msg_kind_q ? f_rise : s_rise) begin
                cnt_d = 32'd0;
            end else if (state_q == BLANK && cnt_q == BLANK_LAST) begin
                state_d = SHOW;
                cnt_d   = 32'd0;
            end else if (state_q == SHOW && cnt_q == HOLD_LAST) begin
                state_d = GAME;
                cnt_d   = 32'd0;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end else begin
            state_d = GAME;
            cnt_d   = 32'd0;
        end
    end

    // Outputs follow the state being entered, so seg/an line up with state_q.
    always_comb begin
        seg_d        = 8'hFF;
        an_d         = 4'hF;
        msg_active_d = (state_d != GAME);
        case (state_d)
            GAME: begin
                seg_d = game_seg;
                an_d  = game_an;
            end
            SHOW: begin
                seg_d = msg_kind_d ? fail_seg : success_seg;
                an_d  = msg_kind_d ? fail_an  : success_an;
            end
            default: begin
                seg_d = 8'hFF;
                an_d  = 4'hF;
            end
        endcase
    end

    always_ff @(posedge basys_clock or posedge reset) begin
        if (reset) begin
            state_q      <= GAME;
            cnt_q        <= 32'd0;
            s_trig_q     <= 1'b0;
            f_trig_q     <= 1'b0;
            msg_kind_q   <= 1'b0;
            msg_active_q <= 1'b0;
            seg_q        <= 8'hFF;
            an_q         <= 4'hF;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            s_trig_q     <= s_trig_d;
            f_trig_q     <= f_trig_d;
            msg_kind_q   <= msg_kind_d;
            msg_active_q <= msg_active_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign msg_active = msg_active_q;
    assign msg_kind   = msg_kind_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_message_display_arbiter.sv
// Bench for message_display_arbiter with short timing (HOLD 20, BLANK 4): table vectors for
// game passthrough, then message scenarios checked against a cycle model through an expected queue.
module tb_message_display_arbiter;

    localparam int HOLD_LEN  = 20;
    localparam int BLANK_LEN = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] game_seg, success_seg, fail_seg;
    logic [3:0] game_an, success_an, fail_an;
    logic       success_trig, fail_trig;
    logic [7:0] seg;
    logic [3:0] an;
    logic       msg_active, msg_kind;
    logic [1:0] dbg_state;

    message_display_arbiter #(
        .HOLD_CYCLES (32'd20),
        .BLANK_CYCLES(32'd4)
    ) dut (
        .basys_clock (clk),
        .reset       (rst),
        .game_seg    (game_seg),
        .game_an     (game_an),
        .success_seg (success_seg),
        .success_an  (success_an),
        .fail_seg    (fail_seg),
        .fail_an     (fail_an),
        .success_trig(success_trig),
        .fail_trig   (fail_trig),
        .seg         (seg),
        .an          (an),
        .msg_active  (msg_active),
        .msg_kind    (msg_kind),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] gseg;
        logic [3:0] gan;
        logic [7:0] exp_seg;
        logic [3:0] exp_an;
    } vec_t;

    vec_t       tbl[6];
    int         checks = 0;
    int         errors = 0;
    logic [13:0] exp_q[$];

    // Cycle model: mode 0 game, 1 blank, 2 show; m_left counts remaining cycles in the phase.
    int   m_mode, m_left;
    logic m_kind, m_sp, m_fp;
    int   act_cnt, show_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_left = 0;
        m_kind = 1'b0;
        m_sp   = 1'b0;
        m_fp   = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_edge();
        logic       sr, fr;
        logic [7:0] es;
        logic [3:0] ea;
        sr = success_trig & ~m_sp;
        fr = fail_trig & ~m_fp;
        m_sp = success_trig;
        m_fp = fail_trig;
        if (m_mode == 0) begin
            if (fr || sr) begin
                m_mode = 1;
                m_left = BLANK_LEN;
                m_kind = fr;
            end
        end else if (fr && !m_kind) begin
            m_mode = 1;
            m_left = BLANK_LEN;
            m_kind = 1'b1;
        end else if ((fr && m_kind) || (sr && !m_kind)) begin
            m_left = (m_mode == 1) ? BLANK_LEN : HOLD_LEN;
        end else begin
            m_left--;
            if (m_left == 0) begin
                if (m_mode == 1) begin
                    m_mode = 2;
                    m_left = HOLD_LEN;
                end else begin
                    m_mode = 0;
                end
            end
        end
        if (m_mode == 0) begin
            es = game_seg;
            ea = game_an;
        end else if (m_mode == 1) begin
            es = 8'hFF;
            ea = 4'hF;
        end else begin
            es = m_kind ? fail_seg : success_seg;
            ea = m_kind ? fail_an : success_an;
        end
        exp_q.push_back({es, ea, (m_mode != 0), m_kind});
    endtask

    task automatic step_check();
        logic [13:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            chk("seg", {24'd0, seg}, {24'd0, e[13:6]});
            chk("an", {28'd0, an}, {28'd0, e[5:2]});
            chk("msg_active", {31'd0, msg_active}, {31'd0, e[1]});
            if (e[1]) chk("msg_kind", {31'd0, msg_kind}, {31'd0, e[0]});
        end
        if (msg_active) act_cnt++;
        if (msg_active && an != 4'hF) show_cnt++;
    endtask

    task automatic rand_src();
        game_seg    = 8'($urandom);
        game_an     = 4'($urandom);
        success_seg = 8'($urandom);
        success_an  = 4'($urandom_range(0, 14));
        fail_seg    = 8'($urandom);
        fail_an     = 4'($urandom_range(0, 14));
    endtask

    task automatic cycle();
        model_edge();
        step_check();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            rand_src();
            cycle();
        end
    endtask

    initial begin
        tbl[0] = '{8'hC0, 4'hE, 8'hC0, 4'hE};
        tbl[1] = '{8'hF9, 4'hD, 8'hF9, 4'hD};
        tbl[2] = '{8'h00, 4'h0, 8'h00, 4'h0};
        tbl[3] = '{8'hFF, 4'hF, 8'hFF, 4'hF};
        tbl[4] = '{8'hA4, 4'h7, 8'hA4, 4'h7};
        tbl[5] = '{8'h5A, 4'hB, 8'h5A, 4'hB};

        rst = 1'b1;
        success_trig = 1'b0;
        fail_trig = 1'b0;
        rand_src();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_seg", {24'd0, seg}, 32'hFF);
        chk("reset_an", {28'd0, an}, 32'hF);
        chk("reset_active", {31'd0, msg_active}, 32'd0);
        chk("reset_kind", {31'd0, msg_kind}, 32'd0);
        rst = 1'b0;

        // Game passthrough, one cycle latency.
        for (int i = 0; i < 6; i++) begin
            game_seg = tbl[i].gseg;
            game_an  = tbl[i].gan;
            exp_q.push_back({tbl[i].exp_seg, tbl[i].exp_an, 1'b0, 1'b0});
            step_check();
        end

        // Level held for 50 cycles produces one message of 24 active cycles.
        act_cnt = 0;
        success_trig = 1'b1;
        run(50);
        success_trig = 1'b0;
        run(10);
        chk("single_event_active_cycles", act_cnt, 32'd24);

        // Simultaneous rises: fail wins.
        success_trig = 1'b1;
        fail_trig = 1'b1;
        run(1);
        chk("simul_kind", {31'd0, msg_kind}, 32'd1);
        success_trig = 1'b0;
        fail_trig = 1'b0;
        run(30);

        // Fail preempts success at show cycle 10; a success rise during FAIL is ignored.
        success_trig = 1'b1;
        run(1);
        run(13);
        fail_trig = 1'b1;
        show_cnt = 0;
        run(1);
        success_trig = 1'b0;
        run(8);
        success_trig = 1'b1;
        run(30);
        chk("preempt_fail_show_cycles", show_cnt, 32'd20);
        success_trig = 1'b0;
        fail_trig = 1'b0;
        run(3);

        // Retrigger at show cycle 15 extends SHOW to 35 cycles.
        show_cnt = 0;
        success_trig = 1'b1;
        run(1);
        success_trig = 1'b0;
        run(18);
        success_trig = 1'b1;
        run(1);
        success_trig = 1'b0;
        run(40);
        chk("retrigger_show_cycles", show_cnt, 32'd35);

        // Asynchronous reset pulse between edges during SHOW.
        success_trig = 1'b1;
        run(12);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_seg", {24'd0, seg}, 32'hFF);
        chk("async_rst_an", {28'd0, an}, 32'hF);
        chk("async_rst_active", {31'd0, msg_active}, 32'd0);
        #2;
        success_trig = 1'b0;
        model_reset();
        rst = 1'b0;
        run(5);

        // Trigger already high when reset releases counts as a rise.
        rst = 1'b1;
        @(posedge clk);
        #1;
        fail_trig = 1'b1;
        model_reset();
        rst = 1'b0;
        act_cnt = 0;
        run(40);
        chk("trig_at_release_active_cycles", act_cnt, 32'd24);
        fail_trig = 1'b0;
        run(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
